// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - execute-stage to divider handshake bundle.
// The execute stage is the master; the divider is the slave.
interface div_unit_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle on operand magnitudes; the sign is fixed up on entry to END.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  div_if
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        ready_q, ready_d;
  logic [63:0] result_q, result_d;

  logic [31:0] op1_mag;
  logic [31:0] op2_mag;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Datapath helpers: operand magnitudes, one restoring trial, final sign fix-up.
  always_comb begin
    op1_mag  = (div_if.signed_div_i && div_if.opdata1_i[31]) ?
               (~div_if.opdata1_i + 32'd1) : div_if.opdata1_i;
    op2_mag  = (div_if.signed_div_i && div_if.opdata2_i[31]) ?
               (~div_if.opdata2_i + 32'd1) : div_if.opdata2_i;
    shifted  = {rem_q, dvd_q[31]};
    fits     = (shifted >= {1'b0, dsr_q});
    // When the trial fits, the true difference is below 2^32, so modulo-32 subtraction is exact.
    diff     = shifted[31:0] - dsr_q;
    quot_fix = neg_quot_q ? (~dvd_q + 32'd1) : dvd_q;
    rem_fix  = neg_rem_q  ? (~rem_q + 32'd1) : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    ready_d    = ready_q;
    result_d   = result_q;

    case (state_q)
      S_FREE: begin
        if (div_if.start_i && !div_if.annul_i) begin
          if (div_if.opdata2_i == 32'd0) begin
            state_d = S_BYZERO;
          end else begin
            state_d    = S_ON;
            dvd_d      = op1_mag;
            dsr_d      = op2_mag;
            rem_d      = 32'd0;
            cnt_d      = 6'd0;
            neg_quot_d = div_if.signed_div_i &
                         (div_if.opdata1_i[31] ^ div_if.opdata2_i[31]);
            neg_rem_d  = div_if.signed_div_i & div_if.opdata1_i[31];
          end
        end
      end

      S_BYZERO: begin
        state_d  = S_END;
        ready_d  = 1'b1;
        result_d = 64'h0;
      end

      S_ON: begin
        if (div_if.annul_i) begin
          state_d  = S_FREE;
          cnt_d    = 6'd0;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end else if (cnt_q == 6'd32) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {rem_fix, quot_fix};
        end else begin
          // The dividend register doubles as the quotient shift register.
          rem_d = fits ? diff : shifted[31:0];
          dvd_d = {dvd_q[30:0], fits};
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_END: begin
        if (!div_if.start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end
      end

      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = 64'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= 6'd0;
      rem_q      <= 32'd0;
      dvd_q      <= 32'd0;
      dsr_q      <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= 64'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed bench for div_unit with a cycle-level reference model.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if dif();

  div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif.slave)
  );

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'h0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: an accepted request yields its arithmetic result a fixed number of edges later.
  int          m_cnt   = 0;
  logic        m_busy  = 1'b0;
  logic        m_zero  = 1'b0;
  logic        m_ready = 1'b0;
  logic [63:0] m_pend  = 64'h0;
  logic [63:0] m_res   = 64'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_res   <= 64'h0;
      m_cnt   <= 0;
    end else if (m_ready) begin
      if (!dif.start_i) begin
        m_ready <= 1'b0;
        m_res   <= 64'h0;
      end
    end else if (m_busy) begin
      if (dif.annul_i && !m_zero) begin
        m_busy <= 1'b0;
      end else if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_res   <= m_pend;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (dif.start_i && !dif.annul_i) begin
      m_busy <= 1'b1;
      m_zero <= (dif.opdata2_i == 32'd0);
      m_cnt  <= (dif.opdata2_i == 32'd0) ? 1 : 33;
      m_pend <= ref_div(dif.opdata1_i, dif.opdata2_i, dif.signed_div_i);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_int("cmp_ready", int'(dif.ready_o), int'(m_ready));
      check64("cmp_result", dif.result_o, m_res);
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp, input int exp_lat,
                        input int hold);
    int n;
    @(negedge clk);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    @(negedge clk);
    n = 1;
    dif.opdata1_i = $urandom;
    dif.opdata2_i = $urandom;
    while (!dif.ready_o && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_int({name, "_latency"}, n - 1, exp_lat);
    check64(name, dif.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      dif.annul_i = 1'b1;
      @(negedge clk);
      check_int({name, "_hold_ready"}, int'(dif.ready_o), 1);
      check64({name, "_hold_result"}, dif.result_o, exp);
    end
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    @(negedge clk);
    check_int({name, "_drop_ready"}, int'(dif.ready_o), 0);
    check64({name, "_drop_result"}, dif.result_o, 64'h0);
  endtask

  initial begin
    int seen;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd0;
    dif.opdata2_i    = 32'd0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;

    check64("model_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    check64("model_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check64("model_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0, 32'h8000_0000});

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check_int("reset_ready", int'(dif.ready_o), 0);
    check64("reset_result", dif.result_o, 64'h0);
    rst = 1'b0;

    run_op("u_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
    run_op("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, 33, 0);
    run_op("u_div0", 32'd5, 32'd0, 1'b0, 64'h0, 1, 0);
    run_op("s_div0", 32'd5, 32'd0, 1'b1, 64'h0, 1, 0);

    // Annul ten cycles into the operation; nothing may come out.
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    dif.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) seen++;
    end
    check_int("annul_no_ready", seen, 0);
    run_op("u_after_annul", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 33, 0);

    // Reset twenty cycles into the operation.
    @(negedge clk);
    dif.opdata1_i = 32'd77;
    dif.opdata2_i = 32'd5;
    dif.start_i   = 1'b1;
    repeat (20) @(negedge clk);
    rst         = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_int("midrst_ready", int'(dif.ready_o), 0);
    check64("midrst_result", dif.result_o, 64'h0);
    run_op("u_after_rst", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, 0);

    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 5);
    run_op("u_0_3", 32'd0, 32'd3, 1'b0, 64'h0, 33, 5);
    run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 33, 0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
